mem_dump_tx: RTL
================

// Module: mem_dump_tx
// PURPOSE
//  Hardware readback of instruction/data memory: on a start pulse, reads a word range
//  through a synchronous BRAM read port and streams it out a UART TX line (8N1).
//  Board-side counterpart of the bench's hex program load; sits beside top, sharing the memory read port.
// PARAMETERS
//  CLK_FREQ    100_000_000  system clock frequency, Hz
//  BAUD        115200       UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (868 at defaults), integer divide
//  ADDR_WIDTH  10           word-address width of the memory port
// PORTS
//  clk         in   1             system clock, rising edge
//  rst         in   1             asynchronous, active-high reset
//  start       in   1             one-cycle request; sampled only when busy=0
//  base_addr   in   ADDR_WIDTH    first word address, latched on accepted start
//  word_count  in   ADDR_WIDTH+1  number of words to send, latched on accepted start
//  mem_en      out  1             memory read enable
//  mem_addr    out  ADDR_WIDTH    memory word address
//  mem_rdata   in   32            read data, valid exactly 1 cycle after mem_en=1
//  tx          out  1             UART serial out, idle high
//  busy        out  1             high from cycle after accepted start until done pulse
//  done        out  1             one-cycle pulse at end of dump
// BEHAVIOUR
//  - Reset (any time, incl. mid-frame): tx=1, busy=0, done=0, mem_en=0, mem_addr=0,
//    FSM->IDLE, counters cleared; no partial frame resumes.
//  - FSM: IDLE -> READ (mem_en=1, mem_addr=cur) -> WAIT -> LOAD (capture mem_rdata into
//    32b shift reg) -> START -> DATA x8 -> STOP -> {next byte: START | next word: READ |
//    last: CKSUM or FIN} -> FIN (done=1, busy drops same cycle) -> IDLE.
//  - start with busy=1 ignored. start with word_count=0: no memory read, no frame; done pulses
//    on the 2nd cycle after start (busy high 1 cycle). CHECKSUM_EN exception below.
//  - First start bit (tx=0) begins 4 cycles after the start-sampling edge (READ,WAIT,LOAD).
//  - Each bit held exactly CLKS_PER_BIT cycles; data LSB first; stop bit high.
//  - Bytes of a word sent little-endian (bits [7:0] first); 4 bytes contiguous, no gap.
//  - Between words: tx held high exactly 3 extra cycles after stop bit (READ,WAIT,LOAD).
//  - Address increments by 1 per word, wraps modulo 2^ADDR_WIDTH (0x3FF -> 0x000).
//  - word_count counter decremented on each LOAD; word_count=2^ADDR_WIDTH dumps whole memory.
//  - mem_en high only in READ state; mem_addr holds last value otherwise.
//  - Inputs base_addr/word_count may change while busy; latched copies used.
// CONFIGURATION
//  MEM_DUMP_CHECKSUM_EN defined: after last data byte, one extra 8N1 byte sent immediately
//    (no gap) = mod-256 sum of all data bytes sent; word_count=0 sends single 0x00 byte then done.
//  Not defined: no trailer byte; checksum logic absent; word_count=0 behaves as above.
// TESTING
//  1. mem[0x010]=0x12345678, base=0x010, count=1 -> tx bytes 78 56 34 12, each bit 868 cycles,
//     one mem_en pulse at addr 0x010, done 1 cycle after last stop bit.
//  2. base=0x3FF, count=2, mem[0x3FF]=0xAABBCCDD, mem[0]=0x01020304 -> reads 0x3FF then 0x000;
//     bytes DD CC BB AA 04 03 02 01; tx high 3 extra cycles between words.
//  3. count=0 -> no mem_en, tx stays 1, done pulse 2 cycles after start (CHECKSUM_EN: one 0x00 frame).
//  4. start re-asserted mid-dump with new base -> ignored; original stream completes unchanged.
//  5. rst asserted mid data bit of byte 2 -> tx=1, busy=0, mem_en=0 same cycle; new start
//     after release dumps from fresh base correctly.
//  6. CHECKSUM_EN, count=1, word 0x12345678 -> trailer byte 0x14 (0x78+0x56+0x34+0x12 mod 256).

Source files
------------

// File: rtl/mem_dump_tx.sv
// mem_dump_tx
//   Reads a range of 32-bit words through a synchronous BRAM read port and
//   streams them out of a UART TX line as 8N1 frames. Bytes go out
//   little-endian (bits [7:0] first), data bits LSB first.
//
//   Optional feature, selected by the macro MEM_DUMP_CHECKSUM_EN:
//   one trailer byte follows the last data byte immediately. It holds the
//   mod-256 sum of all data bytes. With word_count=0 a single 0x00 byte is sent.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   start      : one-cycle request; only honoured while idle
//   base_addr  : first word address, latched on an accepted start
//   word_count : number of words to send, latched on an accepted start
//   mem_en     : memory read enable (one cycle per word)
//   mem_addr   : memory word address, holds its last value between reads
//   mem_rdata  : read data, valid the cycle after mem_en
//   tx         : UART serial output, idle high
//   busy       : high from the cycle after an accepted start until done
//   done       : one-cycle pulse at the end of the dump
//
// All outputs are registered. They follow the FSM state one cycle later. The
// state sequence READ, WAIT, LOAD therefore lines up with mem_en and
// mem_rdata, and the first start bit appears four cycles after the start edge.
module mem_dump_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]         BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   WORD_ONE = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_LOAD, S_START, S_DATA, S_STOP, S_FIN
  } state_t;

  state_t state, next_state;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH:0]   words_left;
  logic [31:0]           shreg;
  logic [CW-1:0]         baud_cnt;
  logic [2:0]            bit_idx;
  logic [1:0]            byte_idx;
  logic                  bit_end;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [7:0]            sum;
  logic                  ck_phase;
  logic                  load_ck;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // next-state logic and bit/checksum strobes
  always_comb begin
    next_state = state;
    bit_end    = (baud_cnt == BIT_LAST);
`ifdef MEM_DUMP_CHECKSUM_EN
    // the trailer is loaded either straight from idle (empty dump) or after the last data byte
    load_ck = ((state == S_IDLE) && start && (word_count == '0)) ||
              ((state == S_STOP) && bit_end && (byte_idx == 2'd3) &&
               !ck_phase && (words_left == '0));
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          if (word_count == '0) begin
`ifdef MEM_DUMP_CHECKSUM_EN
            next_state = S_START;
`else
            next_state = S_FIN;
`endif
          end else begin
            next_state = S_READ;
          end
        end else begin
          next_state = S_IDLE;
        end
      end
      S_READ:  next_state = S_WAIT;
      S_WAIT:  next_state = S_LOAD;
      S_LOAD:  next_state = S_START;
      S_START: begin
        if (bit_end) next_state = S_DATA;
        else         next_state = S_START;
      end
      S_DATA: begin
        if (bit_end && (bit_idx == 3'd7)) next_state = S_STOP;
        else                              next_state = S_DATA;
      end
      S_STOP: begin
        if (bit_end) begin
          if (byte_idx != 2'd3) begin
            next_state = S_START;
`ifdef MEM_DUMP_CHECKSUM_EN
          end else if (ck_phase) begin
            next_state = S_FIN;
`endif
          end else if (words_left != '0) begin
            next_state = S_READ;
          end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
            next_state = S_START;
`else
            next_state = S_FIN;
`endif
          end
        end else begin
          next_state = S_STOP;
        end
      end
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // datapath: address/word counters, shift register, bit timing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr   <= '0;
      words_left <= '0;
      shreg      <= 32'd0;
      baud_cnt   <= '0;
      bit_idx    <= 3'd0;
      byte_idx   <= 2'd0;
`ifdef MEM_DUMP_CHECKSUM_EN
      sum        <= 8'd0;
      ck_phase   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= 3'd0;
          if (start) begin
            cur_addr   <= base_addr;
            words_left <= word_count;
            byte_idx   <= 2'd0;
`ifdef MEM_DUMP_CHECKSUM_EN
            sum      <= 8'd0;
            ck_phase <= load_ck;
            if (load_ck) begin
              shreg    <= 32'd0;
              byte_idx <= 2'd3;
            end else begin
              shreg <= shreg;
            end
`endif
          end else begin
            cur_addr <= cur_addr;
          end
        end
        S_LOAD: begin
          shreg      <= mem_rdata;
          cur_addr   <= cur_addr + ADDR_ONE;   // wraps naturally at 2^ADDR_WIDTH
          words_left <= words_left - WORD_ONE;
          byte_idx   <= 2'd0;
          baud_cnt   <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
          sum <= sum + mem_rdata[7:0] + mem_rdata[15:8] +
                 mem_rdata[23:16] + mem_rdata[31:24];
`endif
        end
        S_START: begin
          baud_cnt <= bit_end ? '0 : baud_cnt + CNT_ONE;
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shreg    <= shreg >> 1;       // next byte slides into [7:0] after 8 shifts
            bit_idx  <= bit_idx + 3'd1;
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            byte_idx <= byte_idx + 2'd1;
`ifdef MEM_DUMP_CHECKSUM_EN
            if (load_ck) begin
              shreg    <= {24'd0, sum};
              ck_phase <= 1'b1;
              byte_idx <= 2'd3;
            end else begin
              ck_phase <= ck_phase;
            end
`endif
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end
        default: begin
          baud_cnt <= '0;
        end
      endcase
    end
  end

  // registered outputs decoded from the current state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        S_START: tx <= 1'b0;
        S_DATA:  tx <= shreg[0];
        default: tx <= 1'b1;
      endcase
      mem_en <= (state == S_READ);
      if (state == S_READ) mem_addr <= cur_addr;
      else                 mem_addr <= mem_addr;
      // busy drops on the same edge that raises done
      busy <= (next_state != S_IDLE);
      done <= (state == S_FIN);
    end
  end

endmodule
